// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port,
// traps on illegal opcodes or memory timeouts, and counts retired instructions.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  opcode_i,
    input  logic        branch_taken_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_addr_sel_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic [1:0]  pc_src_o,
    output logic        reg_write_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  state_o,
    output logic        retire_o,
    output logic [31:0] retired_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o
);

    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd7
    } state_e;

    typedef enum logic [2:0] {ClsIll, ClsBr, ClsJ, ClsJal, ClsAlu, ClsLw, ClsSw} cls_e;

    function automatic cls_e classify(input logic [5:0] op);
        case (op)
            6'd1, 6'd4, 6'd5, 6'd6:          classify = ClsBr;
            6'd2:                            classify = ClsJ;
            6'd3:                            classify = ClsJal;
            6'd0, 6'd8, 6'd9, 6'd13, 6'd15:  classify = ClsAlu;
            6'd35:                           classify = ClsLw;
            6'd43:                           classify = ClsSw;
            default:                         classify = ClsIll;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q;
    logic [5:0]      opcode_q;
    logic [1:0]      trap_cause_q, trap_cause_d;
    logic [31:0]     retired_q;

    cls_e       exec_cls;
    logic       timeout_hit;
    logic       mem_wait;
    logic       req, we, addr_sel, ir_write, pc_write, reg_write, retire;
    logic [1:0] pc_src, wb_sel;

    assign exec_cls = classify(opcode_q);
    assign mem_wait = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready_i;
    // The counter holds prior wait cycles, so TIMEOUT-1 means this is the TIMEOUT-th one.
    assign timeout_hit = (TIMEOUT != 0) && mem_wait && (wait_cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        req          = 1'b0;
        we           = 1'b0;
        addr_sel     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        reg_write    = 1'b0;
        wb_sel       = 2'b00;
        retire       = 1'b0;
        case (state_q)
            StFetch: begin
                req = 1'b1;
                if (mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (timeout_hit) begin
                    state_d      = StTrap;
                    trap_cause_d = 2'b10;
                end
            end
            StDecode: begin
                if (classify(opcode_i) == ClsIll) begin
                    state_d      = StTrap;
                    trap_cause_d = 2'b01;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                unique case (exec_cls)
                    ClsBr: begin
                        pc_write = branch_taken_i;
                        pc_src   = 2'b01;
                        retire   = 1'b1;
                        state_d  = StFetch;
                    end
                    ClsJ, ClsJal: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        retire   = 1'b1;
                        state_d  = StFetch;
                        if (exec_cls == ClsJal) begin
                            reg_write = 1'b1;
                            wb_sel    = 2'b11;
                        end
                    end
                    ClsAlu:       state_d = StWb;
                    ClsLw, ClsSw: state_d = StMem;
                    default: begin
                        state_d      = StTrap;
                        trap_cause_d = 2'b01;
                    end
                endcase
            end
            StMem: begin
                req      = 1'b1;
                addr_sel = 1'b1;
                we       = (exec_cls == ClsSw);
                if (mem_ready_i) begin
                    if (exec_cls == ClsSw) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout_hit) begin
                    state_d      = StTrap;
                    trap_cause_d = 2'b10;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                wb_sel    = (exec_cls == ClsLw) ? 2'b01 : 2'b00;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StTrap: ;
            default: begin
                state_d      = StTrap;
                trap_cause_d = 2'b01;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StFetch;
            wait_cnt_q   <= '0;
            opcode_q     <= '0;
            trap_cause_q <= 2'b00;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
            if (state_q == StDecode) opcode_q <= opcode_i;
            if (retire) retired_q <= retired_q + 32'd1;
            if (state_d != state_q) begin
                wait_cnt_q <= '0;
            end else if (mem_wait) begin
                wait_cnt_q <= wait_cnt_q + CntW'(1);
            end
        end
    end

    // Everything reads as zero (FETCH) while reset is held, whatever the old state was.
    always_comb begin
        mem_req_o      = req & ~rst_i;
        mem_we_o       = we & ~rst_i;
        mem_addr_sel_o = addr_sel & ~rst_i;
        ir_write_o     = ir_write & ~rst_i;
        pc_write_o     = pc_write & ~rst_i;
        pc_src_o       = rst_i ? 2'b00 : pc_src;
        reg_write_o    = reg_write & ~rst_i;
        wb_sel_o       = rst_i ? 2'b00 : wb_sel;
        state_o        = rst_i ? 3'd0 : state_q;
        retire_o       = retire & ~rst_i;
        retired_o      = rst_i ? 32'd0 : retired_q;
        trap_o         = (state_q == StTrap) & ~rst_i;
        trap_cause_o   = rst_i ? 2'b00 : trap_cause_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push expected retire-cycle
// outputs; a monitor pops them on retire_o and also records a per-cycle trace.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [5:0]  opcode_i;
    logic        branch_taken_i;
    logic        mem_ready_i;
    logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o, pc_write_o;
    logic [1:0]  pc_src_o, wb_sel_o, trap_cause_o;
    logic        reg_write_o, retire_o, trap_o;
    logic [2:0]  state_o;
    logic [31:0] retired_o;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .opcode_i      (opcode_i),
        .branch_taken_i(branch_taken_i),
        .mem_ready_i   (mem_ready_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_sel_o(mem_addr_sel_o),
        .ir_write_o    (ir_write_o),
        .pc_write_o    (pc_write_o),
        .pc_src_o      (pc_src_o),
        .reg_write_o   (reg_write_o),
        .wb_sel_o      (wb_sel_o),
        .state_o       (state_o),
        .retire_o      (retire_o),
        .retired_o     (retired_o),
        .trap_o        (trap_o),
        .trap_cause_o  (trap_cause_o)
    );

    typedef struct {
        logic        pc_write;
        logic [1:0]  pc_src;
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic        mem_we;
        logic [31:0] retired;
        int          cycles;
    } exp_t;

    typedef struct {
        logic [2:0]  state;
        logic        req, we, sel, irw, pcw, rw, ret, trap;
        logic [1:0]  cause;
        logic [31:0] retired;
    } tr_t;

    exp_t        sb[$];
    tr_t         trace[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] model_retired = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic tr_t tr(input int i);
        tr_t z;
        z = '{state: 3'd5, req: 1'b1, we: 1'b1, sel: 1'b0, irw: 1'b1, pcw: 1'b1, rw: 1'b1,
              ret: 1'b1, trap: 1'b0, cause: 2'b11, retired: 32'hdead_beef};
        if (i < trace.size()) z = trace[i];
        return z;
    endfunction

    // Monitor: per-cycle trace plus scoreboard pop on every retire pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_i) begin
            cyc = 0;
        end else begin
            cyc++;
            trace.push_back('{state: state_o, req: mem_req_o, we: mem_we_o, sel: mem_addr_sel_o,
                              irw: ir_write_o, pcw: pc_write_o, rw: reg_write_o, ret: retire_o,
                              trap: trap_o, cause: trap_cause_o, retired: retired_o});
            if (retire_o) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_retire: got retire at state %0d, expected none",
                             state_o);
                end else begin
                    e = sb.pop_front();
                    chk("retire_pc_write", {31'd0, pc_write_o}, {31'd0, e.pc_write});
                    chk("retire_pc_src", {30'd0, pc_src_o}, {30'd0, e.pc_src});
                    chk("retire_reg_write", {31'd0, reg_write_o}, {31'd0, e.reg_write});
                    chk("retire_wb_sel", {30'd0, wb_sel_o}, {30'd0, e.wb_sel});
                    chk("retire_mem_we", {31'd0, mem_we_o}, {31'd0, e.mem_we});
                    chk("retire_count", retired_o, e.retired);
                    chk("retire_latency", cyc, e.cycles);
                end
                cyc = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic taken, input int fw, input int mw);
        exp_t e;
        bit   is_mem;
        bit   has_wb;
        e.pc_write = 1'b0; e.pc_src = 2'b00; e.reg_write = 1'b0; e.wb_sel = 2'b00;
        e.mem_we = 1'b0; e.cycles = fw + 3;
        is_mem = 1'b0; has_wb = 1'b0;
        case (op)
            6'd1, 6'd4, 6'd5, 6'd6: begin e.pc_write = taken; e.pc_src = 2'b01; end
            6'd2: begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
            6'd3: begin
                e.pc_write = 1'b1; e.pc_src = 2'b10; e.reg_write = 1'b1; e.wb_sel = 2'b11;
            end
            6'd35: begin is_mem = 1'b1; has_wb = 1'b1; e.reg_write = 1'b1; e.wb_sel = 2'b01; end
            6'd43: begin is_mem = 1'b1; e.mem_we = 1'b1; end
            default: begin has_wb = 1'b1; e.reg_write = 1'b1; end
        endcase
        if (is_mem) e.cycles += mw + 1;
        if (has_wb) e.cycles += 1;
        e.retired = model_retired;
        model_retired = model_retired + 32'd1;
        sb.push_back(e);

        branch_taken_i = ~taken;
        for (int i = 0; i < fw; i++) begin mem_ready_i = 1'b0; step(); end
        mem_ready_i = 1'b1; opcode_i = op; step();
        mem_ready_i = 1'b0; step();
        opcode_i = 6'h3f; branch_taken_i = taken; step();
        branch_taken_i = ~taken;
        if (is_mem) begin
            for (int i = 0; i < mw; i++) step();
            mem_ready_i = 1'b1; step();
            mem_ready_i = 1'b0;
        end
        if (has_wb) step();
    endtask

    // Fetch (zero wait), decode and exec of an op whose outcome the caller checks by hand.
    task automatic fde(input logic [5:0] op);
        mem_ready_i = 1'b1; opcode_i = op; step();
        mem_ready_i = 1'b0; step();
        opcode_i = 6'h3f; step();
    endtask

    task automatic reset_pulse();
        rst_i = 1'b1; step();
        rst_i = 1'b0;
        model_retired = 32'd0;
    endtask

    initial begin
        int n_mem;
        int n_hold;
        logic strobes;
        rst_i = 1'b1; opcode_i = 6'd0; branch_taken_i = 1'b0; mem_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_state", {29'd0, state_o}, 32'd0);
        chk("reset_outputs", {18'd0, mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o, pc_write_o,
            pc_src_o, reg_write_o, wb_sel_o, retire_o, trap_o, trap_cause_o}, 32'd0);
        chk("reset_retired", retired_o, 32'd0);
        step();
        rst_i = 1'b0;

        // ALU then ALU: state walk and first request right after reset.
        trace.delete();
        run_instr(6'd0, 1'b0, 0, 0);
        run_instr(6'd8, 1'b0, 0, 0);
        chk("alu_state_seq", {17'd0, tr(0).state, tr(1).state, tr(2).state, tr(3).state,
            tr(4).state}, {17'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0});
        chk("first_req_after_reset", {31'd0, tr(0).req}, 32'd1);

        // LW with two fetch wait cycles.
        trace.delete();
        run_instr(6'd35, 1'b0, 2, 0);
        chk("lw_fetch_wait", {30'd0, tr(0).req, tr(0).irw}, 32'b10);
        chk("lw_fetch_ready", {29'd0, tr(2).req, tr(2).irw, tr(2).pcw}, 32'b111);
        chk("lw_decode_no_req", {28'd0, tr(3).state, tr(3).req}, {28'd0, 3'd1, 1'b0});
        chk("lw_mem", {26'd0, tr(5).state, tr(5).req, tr(5).sel, tr(5).we},
            {26'd0, 3'd3, 1'b1, 1'b1, 1'b0});
        chk("lw_wb_no_req", {28'd0, tr(6).state, tr(6).req}, {28'd0, 3'd4, 1'b0});

        // Branches, jumps, a waited ALU op and a SW that completes on its last allowed cycle.
        run_instr(6'd4, 1'b0, 0, 0);
        run_instr(6'd4, 1'b1, 0, 0);
        run_instr(6'd3, 1'b0, 0, 0);
        run_instr(6'd2, 1'b0, 0, 0);
        run_instr(6'd13, 1'b0, 1, 0);
        run_instr(6'd43, 1'b0, 3, 3);

        // SW with memory never ready: trap on the fourth wait cycle.
        trace.delete();
        fde(6'd43);
        mem_ready_i = 1'b0;
        repeat (7) step();
        n_mem = 0;
        strobes = 1'b0;
        for (int i = 0; i < trace.size(); i++) begin
            if (trace[i].state == 3'd3) n_mem++;
            strobes |= trace[i].ret;
        end
        chk("timeout_mem_cycles", n_mem, 4);
        chk("timeout_no_retire", {31'd0, strobes}, 32'd0);
        chk("timeout_trap", {27'd0, tr(7).state, tr(7).trap, tr(7).cause},
            {27'd0, 3'd7, 1'b1, 2'b10});
        reset_pulse();

        // Illegal opcode 7: trap after DECODE and hold for 20 cycles.
        trace.delete();
        mem_ready_i = 1'b1; opcode_i = 6'd7; step();
        mem_ready_i = 1'b0; step();
        repeat (20) step();
        n_hold = 0;
        strobes = 1'b0;
        for (int i = 2; i < trace.size(); i++) begin
            if (trace[i].state == 3'd7 && trace[i].trap && trace[i].cause == 2'b01) n_hold++;
            strobes |= trace[i].req | trace[i].we | trace[i].irw | trace[i].pcw |
                       trace[i].rw | trace[i].ret;
        end
        chk("illegal_trap_hold", n_hold, 20);
        chk("illegal_no_strobes", {31'd0, strobes}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk); #1;
        chk("trap_reset_cycle", {26'd0, state_o, trap_o, trap_cause_o, mem_req_o}, 32'd0);
        step();
        rst_i = 1'b0;
        model_retired = 32'd0;
        trace.delete();
        run_instr(6'd0, 1'b0, 0, 0);
        chk("trap_cleared", {26'd0, tr(0).state, tr(0).trap, tr(0).cause, tr(0).req},
            {26'd0, 3'd0, 1'b0, 2'b00, 1'b1});
        chk("retired_cleared", tr(0).retired, 32'd0);

        // Preload the retired counter just below wrap.
        force dut.retired_q = 32'hFFFF_FFFE;
        #1;
        release dut.retired_q;
        model_retired = 32'hFFFF_FFFE;
        run_instr(6'd0, 1'b0, 0, 0);
        run_instr(6'd9, 1'b0, 0, 0);
        run_instr(6'd15, 1'b0, 0, 0);
        run_instr(6'd0, 1'b0, 0, 0);

        // Reset in the middle of an LW memory access.
        trace.delete();
        fde(6'd35);
        mem_ready_i = 1'b0; step();
        rst_i = 1'b1; mem_ready_i = 1'b1;
        @(negedge clk); #1;
        chk("midmem_reset_strobes", {25'd0, mem_req_o, mem_we_o, ir_write_o, pc_write_o,
            reg_write_o, retire_o, trap_o}, 32'd0);
        step();
        rst_i = 1'b0; mem_ready_i = 1'b0;
        model_retired = 32'd0;
        chk("midmem_was_in_mem", {28'd0, tr(3).state, tr(3).req}, {28'd0, 3'd3, 1'b1});
        run_instr(6'd0, 1'b0, 0, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
